// File: rtl/memwb_pkg.sv
// memwb_pkg: default widths and payload field order for the MEM/WB stage.
// Shared by memwb_pipe and memwb_skid.
package memwb_pkg;

  localparam int MEMWB_DATA_W = 8;
  localparam int MEMWB_ADDR_W = 4;
  localparam int MEMWB_PC_W   = 8;

  // Field order of the packed payload, MSB first.
  typedef struct packed {
    logic [MEMWB_ADDR_W-1:0] reg_write_addr;
    logic [MEMWB_DATA_W-1:0] mem_data;
    logic                    reg_write_en;
    logic                    mem_to_reg;
    logic [MEMWB_DATA_W-1:0] alu_out;
    logic [MEMWB_PC_W-1:0]   next_pc;
  } memwb_t;

  function automatic int memwb_pw(int dw, int aw, int pw);
    return aw + dw + 1 + 1 + dw + pw;
  endfunction

endpackage

// File: rtl/memwb_skid.sv
// memwb_skid: two-entry valid/ready buffer over a flat vector, with flush.
// in_ready is a register; no combinational path from out_ready.
module memwb_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_v;
  logic         sk_v;
  logic [W-1:0] out_d;
  logic [W-1:0] sk_d;
  logic         acc;
  logic         ret;

  assign in_ready  = !sk_v;
  assign out_valid = out_v;
  assign out_data  = out_d;
  assign acc       = in_valid && !sk_v;
  assign ret       = out_v && out_ready;

  // Skid is only occupied while the output register is occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v <= 1'b0;
      sk_v  <= 1'b0;
      out_d <= '0;
      sk_d  <= '0;
    end else if (flush) begin
      out_v <= 1'b0;
      sk_v  <= 1'b0;
    end else begin
      unique case (1'b1)
        !out_v: begin
          if (acc) begin
            out_v <= 1'b1;
            out_d <= in_data;
          end
        end
        ret && sk_v: begin
          out_d <= sk_d;
          sk_v  <= 1'b0;
        end
        ret && !sk_v: begin
          out_v <= acc;
          if (acc) out_d <= in_data;
        end
        default: begin
          if (acc) begin
            sk_v <= 1'b1;
            sk_d <= in_data;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/memwb_pipe.sv
// memwb_pipe: MEM/WB register with valid/ready, flush, wb select, stall count.
// MEMWB_SKID_EN adds a two-entry skid buffer (registered in_ready).
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int ADDR_W = MEMWB_ADDR_W,
  parameter int PC_W   = MEMWB_PC_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg_write_addr,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic              in_reg_write_en,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [PC_W-1:0]   in_next_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_reg_write_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              out_mem_to_reg,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [PC_W-1:0]   out_next_pc,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = memwb_pw(DATA_W, ADDR_W, PC_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0] in_pkt;
  logic [PW-1:0] out_pkt;
  logic          out_we;

  assign in_pkt = {in_reg_write_addr, in_mem_data, in_reg_write_en,
                   in_mem_to_reg, in_alu_out, in_next_pc};

  assign {out_reg_write_addr, out_mem_data, out_we,
          out_mem_to_reg, out_alu_out, out_next_pc} = out_pkt;

`ifdef MEMWB_SKID_EN
  memwb_skid #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pkt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pkt)
  );
`else
  logic          out_v;
  logic [PW-1:0] out_q;

  assign in_ready  = !out_v || out_ready;
  assign out_valid = out_v;
  assign out_pkt   = out_q;

  // Single entry: load on accept, empty on retire without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v <= 1'b0;
      out_q <= '0;
    end else if (flush) begin
      out_v <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_v <= 1'b1;
      out_q <= in_pkt;
    end else if (out_v && out_ready) begin
      out_v <= 1'b0;
    end
  end
`endif

  assign wb_en   = out_valid && out_we;
  assign wb_data = out_mem_to_reg ? out_mem_data : out_alu_out;

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
